// File: rtl/msrv32_dbus_pkg.sv
// msrv32_dbus_pkg: state, HTRANS and HSIZE encodings shared by the data-bus controller
package msrv32_dbus_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;
    function automatic logic [2:0] hsize_of(input logic [1:0] size);
        return size == 2'b00 ? HSIZE_BYTE : size == 2'b01 ? HSIZE_HALF : HSIZE_WORD;
    endfunction
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'b01 && addr_lo[0]) || (size[1] && addr_lo != 2'b00);
    endfunction
endpackage

// File: rtl/msrv32_dbus_arbiter.sv
// msrv32_dbus_arbiter: 2-way core/debug grant, fixed priority or round-robin on a last-grant register
module msrv32_dbus_arbiter
    import msrv32_dbus_pkg::*;
#(
    parameter int ARB_RR = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_core_req,
    input  logic i_dbg_req,
    input  logic i_accept,
    output logic o_gnt_dbg
);
    logic r_last_dbg;
    assign o_gnt_dbg = i_dbg_req & (~i_core_req | ((ARB_RR != 0) & ~r_last_dbg));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_dbg <= 1'b1;
        else if (i_accept)
            r_last_dbg <= o_gnt_dbg;
    end
endmodule

// File: rtl/msrv32_dbus_ctrl.sv
// msrv32_dbus_ctrl: LSU/debug to AHB-lite data-bus controller; MSRV32_DBUS_MISALIGN_TRAP_EN enables the misalignment trap
module msrv32_dbus_ctrl
    import msrv32_dbus_pkg::*;
#(
    parameter int ARB_RR = 1,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TMO_W = 9
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        core_req_in,
    input  logic        core_we_in,
    input  logic [1:0]  core_size_in,
    input  logic [31:0] core_addr_in,
    input  logic [31:0] core_wdata_in,
    input  logic [3:0]  core_wmask_in,
    output logic        core_stall_out,
    output logic        core_done_out,
    input  logic        dbg_req_in,
    input  logic        dbg_we_in,
    input  logic [31:0] dbg_addr_in,
    input  logic [31:0] dbg_wdata_in,
    output logic        dbg_done_out,
    output logic [31:0] rdata_out,
    output logic        bus_err_out,
    output logic        misaligned_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  hwstrb_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);
    logic [1:0]       r_state;
    logic [TMO_W-1:0] r_tmo;
    logic             r_err;
    logic             r_gnt_dbg;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mask;
    logic             w_gnt_dbg, w_req, w_grant, w_trap, w_start, w_wait, w_tmo, w_fin, w_err, w_we;
    logic [1:0]       w_size;
    logic [31:0]      w_addr;
    msrv32_dbus_arbiter #(.ARB_RR(ARB_RR)) u_arb (
        .clk(ms_riscv32_mp_clk_in),
        .rst(ms_riscv32_mp_rst_in),
        .i_core_req(core_req_in),
        .i_dbg_req(dbg_req_in),
        .i_accept(w_grant),
        .o_gnt_dbg(w_gnt_dbg)
    );
    assign w_req = core_req_in | dbg_req_in;
    assign w_grant = (r_state == ST_IDLE) & w_req;
    assign w_we = w_gnt_dbg ? dbg_we_in : core_we_in;
    assign w_size = w_gnt_dbg ? 2'b10 : core_size_in;
    assign w_addr = w_gnt_dbg ? dbg_addr_in : core_addr_in;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
    assign w_trap = w_grant & is_misaligned(w_size, w_addr[1:0]);
`else
    assign w_trap = 1'b0;
`endif
    assign w_start = w_grant & ~w_trap;
    // watchdog counts consecutive stalled cycles of the current bus phase
    assign w_wait = (r_state != ST_IDLE) & ~hready_in;
    assign w_tmo = w_wait & (TIMEOUT_CYCLES != 0) & (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_fin = ((r_state == ST_DATA) & hready_in) | w_tmo;
    assign w_err = w_tmo | r_err | ((r_state == ST_DATA) & hresp_in);
    assign core_stall_out = core_req_in & ~core_done_out;
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= ST_IDLE;
            r_tmo <= '0;
            r_err <= 1'b0;
            r_gnt_dbg <= 1'b0;
            r_wdata <= '0;
            r_mask <= '0;
            core_done_out <= 1'b0;
            dbg_done_out <= 1'b0;
            rdata_out <= '0;
            bus_err_out <= 1'b0;
            misaligned_out <= 1'b0;
            haddr_out <= '0;
            htrans_out <= HTRANS_IDLE;
            hwrite_out <= 1'b0;
            hsize_out <= '0;
            hwdata_out <= '0;
            hwstrb_out <= '0;
        end else begin
            core_done_out <= (w_fin & ~r_gnt_dbg) | (w_trap & ~w_gnt_dbg);
            dbg_done_out <= (w_fin & r_gnt_dbg) | (w_trap & w_gnt_dbg);
            bus_err_out <= w_fin & w_err;
            misaligned_out <= w_trap;
            r_tmo <= (w_wait & ~w_tmo) ? r_tmo + 1'b1 : '0;
            if (w_start) begin
                r_state <= ST_ADDR;
                htrans_out <= HTRANS_NONSEQ;
                haddr_out <= w_addr;
                hwrite_out <= w_we;
                hsize_out <= hsize_of(w_size);
                r_wdata <= w_gnt_dbg ? dbg_wdata_in : core_wdata_in;
                r_mask <= w_gnt_dbg ? 4'hF : core_wmask_in;
                r_gnt_dbg <= w_gnt_dbg;
                r_err <= 1'b0;
            end
            if ((r_state == ST_ADDR) & hready_in) begin
                r_state <= ST_DATA;
                htrans_out <= HTRANS_IDLE;
                hwdata_out <= r_wdata;
                hwstrb_out <= r_mask;
            end
            if ((r_state == ST_DATA) & hresp_in)
                r_err <= 1'b1;
            if (w_fin) begin
                r_state <= ST_IDLE;
                htrans_out <= HTRANS_IDLE;
                if (~hwrite_out & ~w_err)
                    rdata_out <= hrdata_in;
            end
        end
    end
endmodule

// File: tb/tb_msrv32_dbus_ctrl.sv
// tb_msrv32_dbus_ctrl: scenario tasks plus randomized transfers checked against a transaction-level model
module tb_msrv32_dbus_ctrl;
    localparam int TMO = 4;
`ifdef MSRV32_DBUS_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic core_req_in = 0, core_we_in = 0, dbg_req_in = 0, dbg_we_in = 0;
    logic [1:0] core_size_in = 0;
    logic [31:0] core_addr_in = 0, core_wdata_in = 0, dbg_addr_in = 0, dbg_wdata_in = 0, hrdata_in = 0;
    logic [3:0] core_wmask_in = 0;
    logic hready_in = 0, hresp_in = 0;
    logic core_stall_out, core_done_out, dbg_done_out, bus_err_out, misaligned_out, hwrite_out;
    logic [31:0] rdata_out, haddr_out, hwdata_out;
    logic [1:0] htrans_out;
    logic [2:0] hsize_out;
    logic [3:0] hwstrb_out;
    int n_checks = 0, n_err = 0;
    int o_lat, o_ns_cyc, o_dp_cyc, o_stall;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [2:0] o_size;
    logic [3:0] o_strb;
    logic [1:0] o_trans_done;
    logic o_write, o_cd, o_dd, o_err, o_mis, o_issued;
    int e_lat;
    bit e_mis, e_err;
    logic [2:0] e_hsize;
    logic [31:0] m_rdata = 0;

    always #5 clk = ~clk;

    msrv32_dbus_ctrl #(.ARB_RR(1), .TIMEOUT_CYCLES(TMO), .TMO_W(3)) dut (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .core_req_in(core_req_in), .core_we_in(core_we_in), .core_size_in(core_size_in),
        .core_addr_in(core_addr_in), .core_wdata_in(core_wdata_in), .core_wmask_in(core_wmask_in),
        .core_stall_out(core_stall_out), .core_done_out(core_done_out),
        .dbg_req_in(dbg_req_in), .dbg_we_in(dbg_we_in), .dbg_addr_in(dbg_addr_in),
        .dbg_wdata_in(dbg_wdata_in), .dbg_done_out(dbg_done_out),
        .rdata_out(rdata_out), .bus_err_out(bus_err_out), .misaligned_out(misaligned_out),
        .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
        .hsize_out(hsize_out), .hwdata_out(hwdata_out), .hwstrb_out(hwstrb_out),
        .hrdata_in(hrdata_in), .hready_in(hready_in), .hresp_in(hresp_in)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // expected outcome of one transfer from transaction-level rules; updates the modelled load data
    task automatic model(input bit dbg, input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input int aw, input int dw, input bit err, input logic [31:0] rd);
        int unsigned bytes;
        bytes = dbg ? 4 : (size == 0 ? 1 : size == 1 ? 2 : 4);
        e_mis = TRAP && (addr % bytes != 0);
        e_lat = e_mis ? 1 : aw >= TMO ? 1 + TMO : dw >= TMO ? 2 + aw + TMO : 3 + aw + dw;
        e_err = !e_mis && (aw >= TMO || dw >= TMO || err);
        e_hsize = bytes == 1 ? 3'd0 : bytes == 2 ? 3'd1 : 3'd2;
        if (!we && !e_mis && !e_err) m_rdata = rd;
    endtask

    // reactive AHB slave plus requester; records what the bus and done outputs showed
    task automatic xfer(input bit dbg, input bit we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, input int aw, input int dw,
                        input bit err, input logic [31:0] rd);
        int ph, wc, cyc;
        bit rdy, done;
        step();
        ph = 0; wc = 0; cyc = 0; done = 0; o_issued = 0; o_stall = 0; o_ns_cyc = -1; o_dp_cyc = -1;
        if (dbg) begin
            dbg_req_in = 1; dbg_we_in = we; dbg_addr_in = addr; dbg_wdata_in = wdata;
        end else begin
            core_req_in = 1; core_we_in = we; core_size_in = size; core_addr_in = addr;
            core_wdata_in = wdata; core_wmask_in = mask;
        end
        hready_in = 0; hresp_in = 0;
        #1 if (core_stall_out) o_stall++;
        while (!done && cyc < 20) begin
            rdy = hready_in;
            step();
            cyc++;
            if (ph == 1 && rdy) begin
                ph = 2; wc = 0; o_dp_cyc = cyc; o_wdata = hwdata_out; o_strb = hwstrb_out;
            end else if (ph == 2 && rdy) ph = 3;
            else if (ph == 1 || ph == 2) wc++;
            if (ph == 0 && htrans_out == 2'b10) begin
                ph = 1; wc = 0; o_issued = 1; o_ns_cyc = cyc;
                o_addr = haddr_out; o_size = hsize_out; o_write = hwrite_out;
            end
            if (core_done_out || dbg_done_out) begin
                done = 1; o_cd = core_done_out; o_dd = dbg_done_out; o_err = bus_err_out;
                o_mis = misaligned_out; o_rdata = rdata_out; o_trans_done = htrans_out;
                core_req_in = 0; dbg_req_in = 0;
            end else if (core_stall_out) o_stall++;
            hready_in = (ph == 1 && wc == aw) || (ph == 2 && wc == dw);
            hresp_in = ph == 2 && err;
            hrdata_in = ph == 2 ? rd : $urandom;
        end
        o_lat = done ? cyc : -1;
        core_req_in = 0; dbg_req_in = 0; hready_in = 0; hresp_in = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) step();
        n_checks++; if (htrans_out !== 2'b00) begin n_err++; $display("FAIL reset_htrans got=%b exp=00", htrans_out); end
        n_checks++; if ({core_done_out, dbg_done_out, bus_err_out, misaligned_out} !== 4'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=0000", {core_done_out, dbg_done_out, bus_err_out, misaligned_out}); end
        n_checks++; if ({rdata_out, haddr_out, hwdata_out} !== 96'b0) begin n_err++; $display("FAIL reset_data got=%h/%h/%h exp=0", rdata_out, haddr_out, hwdata_out); end
        n_checks++; if ({hwrite_out, hsize_out, hwstrb_out} !== 8'b0) begin n_err++; $display("FAIL reset_ctrl got=%b exp=0", {hwrite_out, hsize_out, hwstrb_out}); end
        rst = 0;
        m_rdata = 0;
        step();
    endtask

    task automatic test_store_word;
        model(0, 1, 2'b10, 32'h100, 0, 0, 0, 0);
        xfer(0, 1, 2'b10, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0);
        n_checks++; if (o_ns_cyc !== 1) begin n_err++; $display("FAIL store_nonseq_cycle got=%0d exp=1", o_ns_cyc); end
        n_checks++; if ({o_write, o_addr, o_size} !== {1'b1, 32'h100, 3'b010}) begin n_err++; $display("FAIL store_addr_phase got=%b/%h/%b exp=1/00000100/010", o_write, o_addr, o_size); end
        n_checks++; if (o_dp_cyc !== 2 || o_wdata !== 32'hDEADBEEF || o_strb !== 4'hF) begin n_err++; $display("FAIL store_data_phase got=%0d/%h/%h exp=2/deadbeef/f", o_dp_cyc, o_wdata, o_strb); end
        n_checks++; if (o_lat !== 3 || o_cd !== 1'b1 || o_dd !== 1'b0 || o_err !== 1'b0) begin n_err++; $display("FAIL store_done got=%0d/%b/%b/%b exp=3/1/0/0", o_lat, o_cd, o_dd, o_err); end
    endtask

    task automatic test_load_wait;
        model(0, 0, 2'b10, 32'h200, 0, 3, 0, 32'h12345678);
        xfer(0, 0, 2'b10, 32'h200, 32'h0, 4'hF, 0, 3, 0, 32'h12345678);
        n_checks++; if (o_lat !== 6) begin n_err++; $display("FAIL load_wait_lat got=%0d exp=6", o_lat); end
        n_checks++; if (o_stall !== 6) begin n_err++; $display("FAIL load_wait_stall got=%0d exp=6", o_stall); end
        n_checks++; if (o_rdata !== 32'h12345678 || o_err !== 1'b0) begin n_err++; $display("FAIL load_wait_rdata got=%h/%b exp=12345678/0", o_rdata, o_err); end
    endtask

    task automatic test_bus_error;
        model(0, 0, 2'b10, 32'h300, 0, 1, 1, 32'hCAFEF00D);
        xfer(0, 0, 2'b10, 32'h300, 32'h0, 4'hF, 0, 1, 1, 32'hCAFEF00D);
        n_checks++; if (o_lat !== 4 || o_err !== 1'b1) begin n_err++; $display("FAIL bus_err_done got=%0d/%b exp=4/1", o_lat, o_err); end
        n_checks++; if (o_rdata !== 32'h12345678) begin n_err++; $display("FAIL bus_err_rdata got=%h exp=12345678", o_rdata); end
    endtask

    task automatic test_timeout_reset;
        bit seen;
        model(0, 0, 2'b10, 32'h400, 99, 0, 0, 32'h0);
        xfer(0, 0, 2'b10, 32'h400, 32'h0, 4'hF, 99, 0, 0, 32'h0);
        n_checks++; if (o_lat !== 1 + TMO || o_err !== 1'b1 || o_trans_done !== 2'b00) begin n_err++; $display("FAIL tmo_addr got=%0d/%b/%b exp=%0d/1/00", o_lat, o_err, o_trans_done, 1 + TMO); end
        n_checks++; if (o_rdata !== 32'h12345678) begin n_err++; $display("FAIL tmo_rdata got=%h exp=12345678", o_rdata); end
        model(0, 0, 2'b10, 32'h404, 1, 99, 0, 32'h0);
        xfer(0, 0, 2'b10, 32'h404, 32'h0, 4'hF, 1, 99, 0, 32'h0);
        n_checks++; if (o_lat !== e_lat || o_err !== 1'b1) begin n_err++; $display("FAIL tmo_data got=%0d/%b exp=%0d/1", o_lat, o_err, e_lat); end
        step();
        core_req_in = 1; core_we_in = 0; core_size_in = 2'b10; core_addr_in = 32'h40; hready_in = 0;
        step();
        n_checks++; if (htrans_out !== 2'b10) begin n_err++; $display("FAIL rst_mid_nonseq got=%b exp=10", htrans_out); end
        #2 rst = 1;
        #1;
        n_checks++; if (htrans_out !== 2'b00 || haddr_out !== 32'h0) begin n_err++; $display("FAIL rst_mid_async got=%b/%h exp=00/0", htrans_out, haddr_out); end
        step();
        rst = 0; core_req_in = 0; seen = 0; m_rdata = 0;
        repeat (4) begin
            step();
            if (core_done_out || dbg_done_out) seen = 1;
        end
        n_checks++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done got=%b exp=0", seen); end
    endtask

    task automatic test_misalign;
        model(0, 1, 2'b01, 32'h301, 0, 0, 0, 32'h0);
        xfer(0, 1, 2'b01, 32'h301, 32'h0000AB00, 4'h6, 0, 0, 0, 32'h0);
        n_checks++; if (o_lat !== e_lat || o_mis !== e_mis || o_err !== 1'b0) begin n_err++; $display("FAIL misalign_done got=%0d/%b/%b exp=%0d/%b/0", o_lat, o_mis, o_err, e_lat, e_mis); end
        n_checks++; if (o_issued !== !e_mis) begin n_err++; $display("FAIL misalign_issue got=%b exp=%b", o_issued, !e_mis); end
        model(0, 1, 2'b01, 32'h302, 0, 0, 0, 32'h0);
        xfer(0, 1, 2'b01, 32'h302, 32'hAB000000, 4'hC, 0, 0, 0, 32'h0);
        n_checks++; if (o_lat !== 3 || o_mis !== 1'b0 || o_size !== 3'b001) begin n_err++; $display("FAIL aligned_half got=%0d/%b/%b exp=3/0/001", o_lat, o_mis, o_size); end
    endtask

    task automatic test_back_to_back;
        int k, cyc;
        bit who[3];
        int when[3];
        rst = 1;
        step();
        rst = 0; m_rdata = 0; k = 0; cyc = 0;
        step();
        hready_in = 1; hresp_in = 0;
        core_req_in = 1; core_we_in = 1; core_size_in = 2'b10; core_addr_in = 32'h1000; core_wmask_in = 4'hF;
        dbg_req_in = 1; dbg_we_in = 1; dbg_addr_in = 32'h2000;
        while (k < 3 && cyc < 30) begin
            step();
            cyc++;
            if (core_done_out || dbg_done_out) begin
                who[k] = dbg_done_out; when[k] = cyc; k++;
            end
        end
        core_req_in = 0; dbg_req_in = 0; hready_in = 0;
        n_checks++; if (k !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", k); end
        for (int i = 0; i < k; i++) begin
            n_checks++; if (who[i] !== (i % 2 == 1) || when[i] !== 3 * (i + 1)) begin n_err++; $display("FAIL b2b_grant%0d got=dbg%b@%0d exp=dbg%b@%0d", i, who[i], when[i], i % 2 == 1, 3 * (i + 1)); end
        end
    endtask

    task automatic test_random;
        bit dbg, we, err;
        logic [1:0] size;
        logic [31:0] addr, wdata, rd;
        logic [3:0] mask;
        int aw, dw;
        for (int i = 0; i < 40; i++) begin
            dbg = ($urandom % 3) == 0; we = $urandom; size = 2'($urandom); err = ($urandom % 5) == 0;
            addr = $urandom; if ($urandom % 2) addr[1:0] = 2'b00;
            wdata = $urandom; rd = $urandom; mask = 4'($urandom);
            aw = ($urandom % 10 == 0) ? 9 : $urandom_range(0, 3);
            dw = ($urandom % 10 == 0) ? 9 : $urandom_range(0, 3);
            model(dbg, we, size, addr, aw, dw, err, rd);
            xfer(dbg, we, size, addr, wdata, mask, aw, dw, err, rd);
            n_checks++; if (o_lat !== e_lat) begin n_err++; $display("FAIL rnd%0d_lat got=%0d exp=%0d", i, o_lat, e_lat); end
            n_checks++; if (o_cd !== !dbg || o_dd !== dbg) begin n_err++; $display("FAIL rnd%0d_done got=%b%b exp=%b%b", i, o_cd, o_dd, !dbg, dbg); end
            n_checks++; if (o_err !== e_err || o_mis !== e_mis) begin n_err++; $display("FAIL rnd%0d_flags got=%b/%b exp=%b/%b", i, o_err, o_mis, e_err, e_mis); end
            n_checks++; if (o_rdata !== m_rdata || o_trans_done !== 2'b00) begin n_err++; $display("FAIL rnd%0d_rdata got=%h/%b exp=%h/00", i, o_rdata, o_trans_done, m_rdata); end
            n_checks++; if (o_stall !== (dbg ? 0 : e_lat)) begin n_err++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", i, o_stall, dbg ? 0 : e_lat); end
            if (!e_mis) begin
                n_checks++; if (o_ns_cyc !== 1 || o_addr !== addr || o_write !== we || o_size !== e_hsize) begin n_err++; $display("FAIL rnd%0d_addr got=%0d/%h/%b/%b exp=1/%h/%b/%b", i, o_ns_cyc, o_addr, o_write, o_size, addr, we, e_hsize); end
            end
            if (!e_mis && aw < TMO) begin
                n_checks++; if (o_dp_cyc !== 2 + aw || o_wdata !== wdata || o_strb !== (dbg ? 4'hF : mask)) begin n_err++; $display("FAIL rnd%0d_data got=%0d/%h/%h exp=%0d/%h/%h", i, o_dp_cyc, o_wdata, o_strb, 2 + aw, wdata, dbg ? 4'hF : mask); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_wait();
        test_bus_error();
        test_timeout_reset();
        test_misalign();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
